// File: rtl/la_pipe_adder_pkg.sv
// Shared constants for the lookahead adder and the ALU datapath:
// operation encoding and lookahead group geometry.
package la_pipe_adder_pkg;

    localparam int unsigned GROUP_BITS = 4;
    localparam int unsigned BLOCK_BITS = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/la_pipe_adder_if.sv
// Operand/result handshake bundle for la_pipe_adder.
// slave is the adder's view; master is the producer/consumer side.
interface la_pipe_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/la_group_gp.sv
// Four-wide lookahead cell: group generate/propagate plus the three
// internal carries. Used for both the bit level and the group level.
module la_group_gp
    import la_pipe_adder_pkg::*;
(
    input  logic [GROUP_BITS-1:0] g,
    input  logic [GROUP_BITS-1:0] p,
    input  logic                  cin,
    output logic                  grp_g,
    output logic                  grp_p,
    output logic [GROUP_BITS-2:0] carry
);
    assign carry[0] = g[0] | (p[0] & cin);
    assign carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign carry[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;
endmodule

// File: rtl/la_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// on both sides; stage 1 registers generate/propagate, stage 2 resolves carries.
module la_pipe_adder
    import la_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = GROUP_BITS
) (
    input  logic clock,
    input  logic reset_n,
    la_pipe_adder_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP_BITS;
    localparam int unsigned NB = WIDTH / BLOCK_BITS;

    if (GROUP != GROUP_BITS || WIDTH == 0 || (WIDTH % BLOCK_BITS) != 0) begin : g_param_check
        $error("la_pipe_adder: WIDTH must be a nonzero multiple of 16 and GROUP must be 4");
    end

    logic s1_adv, s2_adv;
    logic s1_valid, s2_valid;

    // Stage 1: operand conditioning and per-group generate/propagate
    logic [WIDTH-1:0]           b_eff, bit_g, bit_p;
    logic                       c0;
    logic [NG-1:0]              grp_g, grp_p;
    logic [NG-1:0][2:0]         unused_s1_c;

    assign b_eff = (op_e'(bus.in_sub) == OP_SUB) ? ~bus.in_b : bus.in_b;
    assign c0    = (op_e'(bus.in_sub) == OP_SUB) ? 1'b1 : bus.in_cin;
    assign bit_g = bus.in_a & b_eff;
    assign bit_p = bus.in_a ^ b_eff;

    for (genvar j = 0; j < NG; j++) begin : g_s1_grp
        la_group_gp u_gp (
            .g     (bit_g[GROUP_BITS*j +: GROUP_BITS]),
            .p     (bit_p[GROUP_BITS*j +: GROUP_BITS]),
            .cin   (1'b0),
            .grp_g (grp_g[j]),
            .grp_p (grp_p[j]),
            .carry (unused_s1_c[j])
        );
    end

    logic [WIDTH-1:0] s1_g, s1_p;
    logic [NG-1:0]    s1_gg, s1_gp;
    logic             s1_c0, s1_a_msb, s1_b_msb;

    // Stage 2: block-level lookahead, block ripple, then intra-group carries
    logic [NB:0]      blk_c;
    logic [NB-1:0]    blk_g, blk_p;
    logic [NG-1:0]    grp_c;
    logic [WIDTH-1:0] bit_c, sum_next;
    logic [NG-1:0]    unused_s2_g, unused_s2_p;
    logic             cout_next, ovf_next;

    assign blk_c[0] = s1_c0;

    for (genvar k = 0; k < NB; k++) begin : g_s2_blk
        la_group_gp u_gp (
            .g     (s1_gg[4*k +: 4]),
            .p     (s1_gp[4*k +: 4]),
            .cin   (blk_c[k]),
            .grp_g (blk_g[k]),
            .grp_p (blk_p[k]),
            .carry (grp_c[4*k+1 +: 3])
        );
        assign grp_c[4*k]  = blk_c[k];
        assign blk_c[k+1]  = blk_g[k] | (blk_p[k] & blk_c[k]);
    end

    for (genvar j = 0; j < NG; j++) begin : g_s2_grp
        la_group_gp u_gp (
            .g     (s1_g[GROUP_BITS*j +: GROUP_BITS]),
            .p     (s1_p[GROUP_BITS*j +: GROUP_BITS]),
            .cin   (grp_c[j]),
            .grp_g (unused_s2_g[j]),
            .grp_p (unused_s2_p[j]),
            .carry (bit_c[GROUP_BITS*j+1 +: GROUP_BITS-1])
        );
        assign bit_c[GROUP_BITS*j] = grp_c[j];
    end

    assign sum_next  = s1_p ^ bit_c;
    assign cout_next = blk_c[NB];
    // Same as carry-in(MSB) ^ carry-out(MSB): operands agree in sign, sum does not.
    assign ovf_next  = ~(s1_a_msb ^ s1_b_msb) & (s1_a_msb ^ sum_next[WIDTH-1]);

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_g     <= bit_g;
                s1_p     <= bit_p;
                s1_gg    <= grp_g;
                s1_gp    <= grp_p;
                s1_c0    <= c0;
                s1_a_msb <= bus.in_a[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_next;
                cout_q <= cout_next;
                ovf_q  <= ovf_next;
                zero_q <= ~|sum_next;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_la_pipe_adder.sv
// Bench for la_pipe_adder at WIDTH=32: arithmetic reference model with an
// in-order expectation queue, plus directed latency/stall/reset scenarios.
module tb_la_pipe_adder;
    import la_pipe_adder_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    la_pipe_adder_if #(.WIDTH(W)) bus ();

    la_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];
    int   out_run  = 0;
    int   max_run  = 0;
    logic stall_prev = 1'b0;
    res_t held;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        res_t         r;
        logic [W-1:0] be;
        logic [W:0]   full;
        longint       sa, sb, exact, lim;
        be    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        exact = sub ? (sa - sb) : (sa + sb + longint'(cin));
        lim   = longint'(1) <<< (W - 1);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (exact >= lim) || (exact < -lim);
        r.zero = (full[W-1:0] == '0);
        return r;
    endfunction

    function automatic res_t dut_res();
        return {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, expected sum=%h cout=%b ovf=%b zero=%b",
                      name, act.sum, act.cout, act.ovf, act.zero, exp.sum, exp.cout, exp.ovf, exp.zero);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Scoreboard: stability while stalled, in-order results, run length of output transfers
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            out_run    = 0;
        end else begin
            if (stall_prev) check_res("stall_hold", dut_res(), held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_bit("spurious_out", 1'b1, 1'b0);
                else check_res("result", dut_res(), exp_q.pop_front());
                out_run++;
                if (out_run > max_run) max_run = out_run;
            end else begin
                out_run = 0;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_cin));
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = dut_res();
        end
    end

    task automatic put(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, output int waits);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
        waits        = 0;
        while (1'b1) begin
            @(negedge clock);
            if (bus.in_ready) break;
            waits++;
            if (waits > 100) begin
                check_bit("put_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic lat_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input res_t exp);
        int w;
        put(a, b, sub, cin, w);
        check_bit({name, "_lat1"}, bus.out_valid, 1'b0);
        @(posedge clock); #1;
        check_bit({name, "_lat2"}, bus.out_valid, 1'b1);
        check_res(name, dut_res(), exp);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
        #1;
        check_int(name, exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, acc, k, sent, cyc;
        logic tr;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_res("rst_outputs", dut_res(), '0);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        reset_n = 1'b1;

        // Pin the model to hand-computed values
        check_res("model_wrap", model(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0),
                  '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        check_res("model_sub_ovf", model(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0),
                  '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
        check_res("model_add_ovf", model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0),
                  '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        check_res("model_cin", model(32'h0000_FFFF, 32'h0, 1'b0, 1'b1),
                  '{sum: 32'h0001_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0});

        @(posedge clock); #1;
        lat_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0,
               '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        lat_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
               '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
        lat_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        lat_op("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1,
               '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        lat_op("add_cin", 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b1,
               '{sum: 32'h0001_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0});

        // Back-to-back stream
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            put(32'h1234_5678 * (i + 1), 32'h0F0F_F0F0 ^ i, i[0], i[1], w);
            check_int("stream_ready", w, 0);
        end
        repeat (4) @(posedge clock);
        #1;
        check_int("stream_run", max_run, 8);

        // Back-pressure: two ops fill the pipe, then in_ready drops
        bus.out_ready = 1'b0;
        k = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_a = 32'h1000_0001;
        bus.in_b = 32'h0000_00FF;
        bus.in_sub = 1'b0;
        bus.in_cin = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            tr = bus.in_ready;
            if (tr) acc++;
            @(posedge clock); #1;
            if (tr) begin
                k++;
                bus.in_a   = 32'h1000_0001 * (k + 1);
                bus.in_b   = 32'hFFFF_0000 + k;
                bus.in_sub = k[0];
            end
        end
        check_int("stall_accepted", acc, 2);
        check_bit("stall_in_ready", bus.in_ready, 1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall_drain");

        // Asynchronous reset with both stages full
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        put(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, w);
        put(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, w);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_bit("arst_out_valid", bus.out_valid, 1'b0);
        check_res("arst_outputs", dut_res(), '0);
        check_bit("arst_in_ready", bus.in_ready, 1'b1);
        #3;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        lat_op("post_reset", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0,
               '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});

        // Random valid/ready traffic with corner-biased operands
        sent = 0;
        cyc  = 0;
        while (sent < 300 && cyc < 20000) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (!bus.in_valid && $urandom_range(0, 9) < 7) begin
                bus.in_valid = 1'b1;
                bus.in_a     = pick();
                bus.in_b     = pick();
                bus.in_sub   = 1'($urandom_range(0, 1));
                bus.in_cin   = 1'($urandom_range(0, 1));
            end
            @(negedge clock);
            tr = bus.in_valid && bus.in_ready;
            @(posedge clock); #1;
            if (tr) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        check_int("random_sent", sent, 300);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("random_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
